uart_rx_oversample: RTL
=======================

// Module: uart_rx_oversample
// PURPOSE
//  Standalone 8N1 UART receiver. It recovers bytes from the serial line driven by the
//  existing uart transmitter (loopback) or by an external host.
//  Uses 16x oversampling with a mid-bit sample point, glitch rejection on the start bit,
//  framing-error detection and overrun detection.
//  Presents each byte on dout with a rdy/rdy_clr handshake toward the consuming logic.
// PARAMETERS
//  CLK_FREQ    50_000_000  clock_50MHZ frequency, Hz
//  BAUD        115200      line rate, bit/s
//  OVERSAMPLE  16          ticks per bit; fixed at 16, other values unsupported
//  DIV         CLK_FREQ/(BAUD*OVERSAMPLE)  localparam, integer floor (27 at defaults); must be >= 1
// PORTS
//  clock_50MHZ  in   1  system clock; all logic on its rising edge
//  reset_n      in   1  synchronous, active-low reset
//  rx           in   1  asynchronous serial input; idle high
//  rdy_clr      in   1  consumer acknowledge; clears rdy and overrun
//  dout         out  8  last received byte, LSB received first
//  rdy          out  1  byte available; held until rdy_clr
//  frame_err    out  1  one-cycle pulse: stop bit sampled low
//  overrun      out  1  sticky: a byte completed while rdy was still 1
//  rx_busy      out  1  1 in every state except IDLE
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): state=IDLE, tick counter=0, sample counter=0, bit index=0.
//   Outputs: dout=8'h00, rdy=0, frame_err=0, overrun=0, rx_busy=0.
//   The synchronizer flops are set to 1.
//   Reset mid-frame abandons the frame with no output change beyond the reset values.
//  Synchronizer: rx passes through 2 flops (rx_s); all decisions use rx_s only.
//  Tick: asserted 1 cycle every DIV cycles. Counter wraps DIV-1 -> 0.
//   The counter is zeroed on the IDLE->START transition so the sample phase aligns to the edge.
//  Sample counter s: 4 bits, counts ticks, wraps 15 -> 0.
//  FSM:
//   IDLE:  rx_s==0 -> START, s=0.
//   START: on the tick with s==7, rx_s==0 -> DATA, s=0, bit index=0.
//          On that tick, rx_s==1 -> IDLE; glitch, no flags.
//   DATA:  on the tick with s==15, shift rx_s into shreg[7], shifting right.
//          After bit index 7 -> STOP, s=0.
//   STOP:  on the tick with s==15, the stop bit is sampled.
//          rx_s==1 -> load dout<=shreg, set rdy, go IDLE.
//          rx_s==0 -> frame_err=1 for one cycle; dout and rdy unchanged.
//          From rx_s==0 -> wait in BREAK until rx_s==1, then IDLE.
//   BREAK: holds rx_busy=1; exits only when rx_s==1.
//  Latency: dout/rdy valid on the cycle after the stop-bit sampling tick.
//   That is ~9.5 bit times after the falling edge of the start bit.
//  Handshake: rdy set by a good stop bit; cleared by rdy_clr=1.
//   Set and clear in the same cycle -> set wins (rdy=1).
//  Overrun: good stop bit while rdy==1 -> dout overwritten, overrun<=1.
//   overrun clears with rdy_clr unless a new overrun occurs in the same cycle.
//  Back-to-back frames: IDLE is re-entered at the mid stop bit.
//   A start edge half a bit later is accepted with no lost frame.
//  rx held low forever: one frame_err pulse, then the FSM stays in BREAK; no further pulses.
// STRUCTURE
//  Shared package/include uart_defs.vh:
//   state encodings IDLE=0, START=1, DATA=2, STOP=3, BREAK=4 (3 bits)
//   UART_DATA_BITS=8, UART_OVERSAMPLE=16.
//   The same file is reused by the transmitter.
//  Sub-module uart_baud_tick (params CLK_FREQ, BAUD, OVERSAMPLE; ports clock_50MHZ, reset_n,
//   restart, tick), shareable with the transmitter.
//  FSM, shift register, synchronizer and flags live in this module.
// TESTING
//  Bench params CLK_FREQ=1_600_000, BAUD=100_000 -> DIV=1; one bit = 16 cycles.
//  1. Send 8'hA5 (start, 1,0,1,0,0,1,0,1, stop) -> dout=8'hA5, rdy=1 ~152 cycles after start edge;
//     frame_err=0, overrun=0.
//  2. Low pulse on rx of 5 cycles, then high -> FSM returns to IDLE; rdy, dout and frame_err
//     unchanged; rx_busy falls.
//  3. Send 8'h3C with stop bit=0 -> one frame_err pulse, rdy=0, dout keeps its old value.
//     rx then goes high -> next byte 8'h81 is received correctly.
//  4. Send 8'h11 then 8'h22 back-to-back without rdy_clr -> dout=8'h22, rdy=1, overrun=1.
//     One rdy_clr pulse -> rdy=0, overrun=0.
//  5. rdy_clr=1 in the same cycle rdy would be set by byte 8'hFF -> rdy=1, dout=8'hFF.
//  6. Assert reset_n=0 for 1 cycle in the middle of data bit 4 of 8'h5A -> all outputs at reset values.
//     The next full frame 8'hC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_oversample_pkg.sv
// Shared UART definitions: frame geometry and receiver state encodings.
// Also intended for reuse by the transmitter.
package uart_rx_oversample_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_oversample_baud_tick.sv
// Oversampling tick generator: one-cycle tick every CLK_FREQ/(BAUD*OVERSAMPLE) clocks.
// restart zeroes the divider so the sample phase can be realigned to a line edge.
module uart_baud_tick #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clock_50MHZ,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter, wraps at DIV-1 or is forced to zero by restart
  always_ff @(posedge clock_50MHZ) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling, start-glitch rejection,
// framing-error and overrun detection, and a rdy/rdy_clr handshake.
module uart_rx_oversample
  import uart_rx_oversample_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock_50MHZ,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam logic [3:0] S_MID  = 4'(UART_OVERSAMPLE / 2 - 1);
  localparam logic [3:0] S_LAST = 4'(UART_OVERSAMPLE - 1);
  localparam logic [2:0] B_LAST = 3'(UART_DATA_BITS - 1);

  rx_state_t                  state, state_nxt;
  logic [3:0]                 s, s_nxt;
  logic [2:0]                 bit_idx, bit_nxt;
  logic [UART_DATA_BITS-1:0]  shreg, shreg_nxt;
  logic                       sync1, rx_s;
  logic                       tick, restart, load, ferr;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clock_50MHZ(clock_50MHZ),
    .reset_n    (reset_n),
    .restart    (restart),
    .tick       (tick)
  );

  // Two-flop synchronizer; idles high so reset never looks like a start edge
  always_ff @(posedge clock_50MHZ) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // FSM state, sample counter, bit index and shift register
  always_ff @(posedge clock_50MHZ) begin
    if (!reset_n) begin
      state   <= IDLE;
      s       <= 4'd0;
      bit_idx <= 3'd0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      s       <= s_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // Next-state logic; load/ferr mark the stop-bit decision tick
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    restart   = 1'b0;
    load      = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          s_nxt     = 4'd0;
          restart   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (tick && (s == S_MID)) begin
          s_nxt   = 4'd0;
          bit_nxt = 3'd0;
          state_nxt = rx_s ? IDLE : DATA;
        end else if (tick) begin
          s_nxt = s + 4'd1;
        end else begin
          s_nxt = s;
        end
      end
      DATA: begin
        if (tick && (s == S_LAST)) begin
          s_nxt     = 4'd0;
          shreg_nxt = {rx_s, shreg[UART_DATA_BITS-1:1]};
          if (bit_idx == B_LAST) begin
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else if (tick) begin
          s_nxt = s + 4'd1;
        end else begin
          s_nxt = s;
        end
      end
      STOP: begin
        if (tick && (s == S_LAST)) begin
          s_nxt = 4'd0;
          if (rx_s) begin
            load      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr      = 1'b1;
            state_nxt = BREAK;
          end
        end else if (tick) begin
          s_nxt = s + 4'd1;
        end else begin
          s_nxt = s;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = BREAK;
        end
      end
      default: begin
        state_nxt = IDLE;
        s_nxt     = 4'd0;
        bit_nxt   = 3'd0;
      end
    endcase
  end

  // Registered outputs; a new byte wins over a same-cycle acknowledge
  always_ff @(posedge clock_50MHZ) begin
    if (!reset_n) begin
      dout      <= 8'h00;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      frame_err <= ferr;
      rx_busy   <= (state_nxt != IDLE);
      if (load) begin
        dout <= shreg;
        rdy  <= 1'b1;
      end else if (rdy_clr) begin
        rdy  <= 1'b0;
      end else begin
        rdy  <= rdy;
      end
      if (load && rdy) begin
        overrun <= 1'b1;
      end else if (rdy_clr) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule
